// File: rtl/rhythm_recorder.sv
// Records debounced key presses into a one-bit-per-slot beat map aligned to the 8 Hz slot strobe.
// Press latency is 2 sync + DEBOUNCE_CYCLES + 1 cycles; a map bit appears on map the cycle after its closing tick.
module rhythm_recorder #(
  parameter int MAP_LEN         = 191,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SLOT_W          = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  logic               button,
  output logic               recording,
  output logic               done,
  output logic [MAP_LEN-1:0] map,
  output logic [SLOT_W-1:0]  slot,
  output logic [7:0]         press_count
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ARMED, RECORD, DONE} state_t;

  state_t             state_q, state_d;
  logic               sync1_q, sync2_q;
  logic               db_q, db_d, db_prev_q;
  logic [CNT_W-1:0]   dbcnt_q, dbcnt_d;
  logic               start_q;
  logic               pending_q, pending_d;
  logic [MAP_LEN-1:0] map_q, map_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [7:0]         count_q, count_d;
  logic               start_evt, press_evt, slot_bit;

  assign start_evt = start & ~start_q;
  assign press_evt = db_prev_q & ~db_q;
  assign slot_bit  = pending_q | press_evt;

  // Any cycle where the synchronised key agrees with the debounced level restarts the count.
  always_comb begin
    db_d    = db_q;
    dbcnt_d = '0;
    if (sync2_q != db_q) begin
      if (dbcnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        db_d = sync2_q;
      end else begin
        dbcnt_d = dbcnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    map_d     = map_q;
    slot_d    = slot_q;
    count_d   = count_q;
    pending_d = pending_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_evt) begin
          state_d   = ARMED;
          map_d     = '0;
          slot_d    = '0;
          count_d   = '0;
          pending_d = 1'b0;
        end
      end
      ARMED: begin
        if (start_evt) begin
          state_d = IDLE;
        end else if (tick) begin
          state_d = RECORD;
          slot_d  = '0;
        end
      end
      RECORD: begin
        if (press_evt) begin
          pending_d = 1'b1;
        end
        if (tick) begin
          for (int k = 0; k < MAP_LEN; k++) begin
            if (slot_q == SLOT_W'(k)) begin
              map_d[k] = slot_bit;
            end
          end
          pending_d = 1'b0;
          if (slot_bit && count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
          end
          if (slot_q == SLOT_W'(MAP_LEN - 1)) begin
            state_d = DONE;
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end
        // A stop request freezes the slot index even when it coincides with a closing tick.
        if (start_evt) begin
          state_d   = DONE;
          slot_d    = slot_q;
          pending_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      db_q      <= 1'b1;
      db_prev_q <= 1'b1;
      dbcnt_q   <= '0;
      start_q   <= 1'b0;
      pending_q <= 1'b0;
      map_q     <= '0;
      slot_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= button;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      dbcnt_q   <= dbcnt_d;
      start_q   <= start;
      pending_q <= pending_d;
      map_q     <= map_d;
      slot_q    <= slot_d;
      count_q   <= count_d;
    end
  end

  assign recording   = (state_q == RECORD);
  assign done        = (state_q == DONE);
  assign map         = map_q;
  assign slot        = slot_q;
  assign press_count = count_q;

endmodule
